// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the transmitter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   grant;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, grant, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, grant, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between N_REQ byte streams.
// Each byte is sequenced on the transmitter's ready fall/rise; a watchdog flags a stuck start.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] g_idx_q, g_idx_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;

  logic [PTR_W:0]   pick;
  logic [7:0]       sel_data;
  logic             burst_full;

  // First valid index at or after p, upward with wrap; MSB flags a hit.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(p) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!res[PTR_W] && v[PTR_W'(idx)]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == N_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign pick       = rr_pick(bus.req_valid, rr_ptr_q);
  assign sel_data   = bus.req_data[{g_idx_q, 3'b000} +: 8];
  assign burst_full = (9'(burst_cnt_q) + 9'd1) == 9'(MAX_BURST);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    g_idx_d       = g_idx_q;
    burst_cnt_d   = burst_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    req_ack_d     = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick[PTR_W]) begin
          g_idx_d                 = pick[PTR_W-1:0];
          grant_d[pick[PTR_W-1:0]] = 1'b1;
          burst_cnt_d             = '0;
          state_d                 = LOAD;
        end
      end
      LOAD: begin
        if (bus.req_valid[g_idx_q]) begin
          tx_data_d  = sel_data;
          last_d     = bus.req_last[g_idx_q];
          req_ack_d  = grant_q;
          tx_start_d = 1'b1;
          wd_cnt_d   = '0;
          state_d    = WAIT_BUSY;
        end else begin
          grant_d  = '0;
          rr_ptr_d = wrap_inc(g_idx_q);
          state_d  = IDLE;
        end
      end
      WAIT_BUSY: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (!bus.tx_ready) begin
          state_d = WAIT_DONE;
        end else if (wd_cnt_q == WD_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never took the start: drop the byte and move on.
          timeout_err_d = 1'b1;
          grant_d       = '0;
          rr_ptr_d      = wrap_inc(g_idx_q);
          state_d       = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (last_q || burst_full) begin
            grant_d  = '0;
            rr_ptr_d = wrap_inc(g_idx_q);
            state_d  = IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
            state_d     = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      g_idx_q       <= '0;
      burst_cnt_q   <= '0;
      wd_cnt_q      <= '0;
      last_q        <= 1'b0;
      grant_q       <= '0;
      req_ack_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      g_idx_q       <= g_idx_d;
      burst_cnt_q   <= burst_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      req_ack_q     <= req_ack_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.req_ack  = req_ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration order plus
// hand-written sequences for bursts, early end, watchdog and mid-frame reset.
module tb_uart_tx_arbiter;

  localparam int unsigned FRAME = 40;

  logic clk;
  logic reset;
  logic busy;
  logic timeout_err;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(
    .N_REQ(4),
    .MAX_BURST(3),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  logic [7:0] exp_hold = 8'h00;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: drops ready 2 cycles after sampling start, low for FRAME cycles.
  logic       tx_dead = 1'b0;
  logic [1:0] m_st;
  int         m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.tx_ready <= 1'b1;
      m_st         <= 2'd0;
      m_cnt        <= 0;
    end else begin
      case (m_st)
        2'd0: if (bus.tx_start && !tx_dead) m_st <= 2'd1;
        2'd1: m_st <= 2'd2;
        2'd2: begin
          bus.tx_ready <= 1'b0;
          m_cnt        <= FRAME;
          m_st         <= 2'd3;
        end
        default: begin
          if (m_cnt == 1) begin
            bus.tx_ready <= 1'b1;
            m_st         <= 2'd0;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      endcase
    end
  end

  // Continuous protocol checks: one-cycle start, ack only with start, data held in frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_start) check("start_width", 32'(bus.tx_start), 32'd0);
      if (bus.tx_start) begin
        n_starts <= n_starts + 1;
        check("ack_onehot", 32'($countones(bus.req_ack)), 32'd1);
      end else begin
        check("ack_idle", 32'(bus.req_ack), 32'd0);
      end
      if (m_st == 2'd3) check("data_hold", 32'(bus.tx_data), 32'(exp_hold));
    end
    prev_start <= bus.tx_start & ~reset;
  end

  task automatic expect_start(input string name, input logic [3:0] eg, input logic [7:0] ed,
                              output logic gap);
    logic ok;
    ok  = 1'b0;
    gap = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        ok = 1'b1;
        break;
      end
      if (bus.grant == 4'b0000) gap = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s no tx_start within bound", name);
    end else begin
      exp_hold = ed;
      check({name, "_grant"}, 32'(bus.grant), 32'(eg));
      check({name, "_data"}, 32'(bus.tx_data), 32'(ed));
      check({name, "_ack"}, 32'(bus.req_ack), 32'(eg));
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s busy never dropped", name);
    end
  endtask

  typedef struct packed {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic gap;
    int   n0;

    // Single requester, then round-robin with all lines valid, then sparse masks.
    vec[0] = '{4'b0100, 4'b1111, 32'h00A5_0000, 4'b0100, 8'hA5};
    vec[1] = '{4'b1111, 4'b1111, 32'h4433_2211, 4'b1000, 8'h44};
    vec[2] = '{4'b1111, 4'b1111, 32'h4847_4645, 4'b0001, 8'h45};
    vec[3] = '{4'b1111, 4'b1111, 32'h4C4B_4A49, 4'b0010, 8'h4A};
    vec[4] = '{4'b1111, 4'b1111, 32'h504F_4E4D, 4'b0100, 8'h4F};
    vec[5] = '{4'b1111, 4'b1111, 32'h5453_5251, 4'b1000, 8'h54};
    vec[6] = '{4'b1111, 4'b1111, 32'h5857_5655, 4'b0001, 8'h55};
    vec[7] = '{4'b1001, 4'b1111, 32'h6C00_006B, 4'b1000, 8'h6C};
    vec[8] = '{4'b0110, 4'b1111, 32'h0079_7800, 4'b0010, 8'h78};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    check("rst_start", 32'(bus.tx_start), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      wait_idle($sformatf("vec%0d_idle", r));
      bus.req_valid = vec[r].valid;
      bus.req_last  = vec[r].last;
      bus.req_data  = vec[r].data;
      expect_start($sformatf("vec%0d", r), vec[r].exp_grant, vec[r].exp_data, gap);
    end
    wait_idle("vec_end");
    bus.req_valid = '0;
    check("vec_end_grant", 32'(bus.grant), 32'd0);

    // Burst cap of 3: requester 1 streams 0x10..0x14, regains grant after rotation.
    bus.req_last  = 4'b0000;
    bus.req_data  = 32'h0000_1000;
    bus.req_valid = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      expect_start($sformatf("burst%0d", b), 4'b0010, 8'(8'h10 + b), gap);
      if (b > 0) check($sformatf("burst%0d_gap", b), 32'(gap), (b == 3) ? 32'd1 : 32'd0);
      if (b < 4) bus.req_data = {16'h0000, 8'(8'h11 + b), 8'h00};
      else       bus.req_valid = '0;
    end
    wait_idle("burst_end");

    // Early end: requester 0 drops valid after two bytes, no further start.
    n0            = n_starts;
    bus.req_data  = 32'h0000_0050;
    bus.req_valid = 4'b0001;
    expect_start("early0", 4'b0001, 8'h50, gap);
    bus.req_data = 32'h0000_0051;
    expect_start("early1", 4'b0001, 8'h51, gap);
    bus.req_valid = '0;
    wait_idle("early_idle");
    check("early_starts", 32'(n_starts - n0), 32'd2);
    check("early_grant", 32'(bus.grant), 32'd0);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'h6362_6160;
    expect_start("early_next", 4'b0010, 8'h61, gap);
    bus.req_valid = '0;
    wait_idle("early_next_idle");

    // Watchdog: transmitter never drops ready.
    tx_dead       = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0100;
    bus.req_data  = 32'h0077_0000;
    expect_start("wd", 4'b0100, 8'h77, gap);
    bus.req_valid = '0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("wd_pre%0d", i), 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    check("wd_flag", 32'(timeout_err), 32'd1);
    check("wd_grant", 32'(bus.grant), 32'd0);
    check("wd_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("wd_sticky", 32'(timeout_err), 32'd1);
    tx_dead = 1'b0;

    // Reset in WAIT_DONE, then arbitration restarts from requester 0.
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b1000;
    bus.req_data  = 32'h9900_0000;
    expect_start("mid", 4'b1000, 8'h99, gap);
    for (int i = 0; i < 20 && bus.tx_ready; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_ack", 32'(bus.req_ack), 32'd0);
    check("mid_rst_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_timeout", 32'(timeout_err), 32'd0);
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'hDDCC_BBAA;
    expect_start("post_rst", 4'b0001, 8'hAA, gap);
    bus.req_valid = '0;
    wait_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
